// File: rtl/cnn_batch_norm_weights_loader_if.sv
// Handshake and bank-bus signals for the batch-norm weights loader.
// The slave modport is the loader's view; master is the DMA/config/reader side.
interface cnn_batch_norm_weights_loader_if #(
  parameter int OUTPUT_BRAM_NUM          = 4,
  parameter int DATA_WIDTH               = 32,
  parameter int BATCH_NORM_WEIGHTS_WIDTH = 8
);
  logic                                i_start;
  logic [BATCH_NORM_WEIGHTS_WIDTH-1:0] i_batch_norm_weights_size;
  logic                                i_reset_busy;
  logic                                i_data_valid;
  logic [DATA_WIDTH-1:0]               i_data;
  logic                                o_data_ready;
  logic                                o_enable;
  logic [OUTPUT_BRAM_NUM-1:0]          o_wenable;
  logic [DATA_WIDTH-1:0]               o_bram_data;
  logic [BATCH_NORM_WEIGHTS_WIDTH-1:0] o_data_point;
  logic                                i_rd_req;
  logic [BATCH_NORM_WEIGHTS_WIDTH-1:0] i_rd_index;
  logic                                o_rd_valid;
  logic                                o_rd_error;
  logic                                o_load_done;
  logic                                o_busy;

  modport slave (
    input  i_start, i_batch_norm_weights_size, i_reset_busy, i_data_valid, i_data,
    input  i_rd_req, i_rd_index,
    output o_data_ready, o_enable, o_wenable, o_bram_data, o_data_point,
    output o_rd_valid, o_rd_error, o_load_done, o_busy
  );

  modport master (
    output i_start, i_batch_norm_weights_size, i_reset_busy, i_data_valid, i_data,
    output i_rd_req, i_rd_index,
    input  o_data_ready, o_enable, o_wenable, o_bram_data, o_data_point,
    input  o_rd_valid, o_rd_error, o_load_done, o_busy
  );
endinterface

// File: rtl/cnn_batch_norm_weights_loader.sv
// Loads a weight stream round-robin into OUTPUT_BRAM_NUM banks, then serves
// parallel single-word reads with a fixed-latency valid flag.
module cnn_batch_norm_weights_loader #(
  parameter int OUTPUT_BRAM_NUM          = 4,
  parameter int DATA_WIDTH               = 32,
  parameter int BATCH_NORM_WEIGHTS_WIDTH = 8,
  parameter int READ_LATENCY             = 2
) (
  input logic                          i_clock,
  input logic                          i_reset,
  cnn_batch_norm_weights_loader_if.slave bus
);
  localparam int W      = BATCH_NORM_WEIGHTS_WIDTH;
  localparam int BANK_W = (OUTPUT_BRAM_NUM > 1) ? $clog2(OUTPUT_BRAM_NUM) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_RST, LOAD, READY} state_t;

  state_t                     state;
  logic [W-1:0]               size_q;
  logic [W-1:0]               addr_cnt;
  logic [BANK_W-1:0]          bank_cnt;
  logic                       enable;
  logic [OUTPUT_BRAM_NUM-1:0] wenable;
  logic [DATA_WIDTH-1:0]      bram_data;
  logic [W-1:0]               data_point;
  logic                       rd_error;
  logic                       rd_issue;
  logic [READ_LATENCY-1:0]    rd_pipe;

  logic xfer;
  logic last_bank;
  logic last_addr;
  logic start_ok;

  // Ready drops combinationally with reset-busy so no word is taken while a bank is busy.
  assign bus.o_data_ready = (state == LOAD) && !bus.i_reset_busy;
  assign xfer      = bus.i_data_valid && bus.o_data_ready;
  assign last_bank = (bank_cnt == BANK_W'(OUTPUT_BRAM_NUM - 1));
  assign last_addr = (addr_cnt == size_q - W'(1));
  assign start_ok  = bus.i_start && ((state == IDLE) || (state == READY));

  assign bus.o_enable     = enable;
  assign bus.o_wenable    = wenable;
  assign bus.o_bram_data  = bram_data;
  assign bus.o_data_point = data_point;
  assign bus.o_rd_error   = rd_error;
  assign bus.o_rd_valid   = rd_pipe[READ_LATENCY-1];
  assign bus.o_load_done  = (state == READY);
  assign bus.o_busy       = (state == WAIT_RST) || (state == LOAD);

  // NOTE: state lives in always_ff with <= only; blocking writes here would race other flops.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      size_q     <= '0;
      addr_cnt   <= '0;
      bank_cnt   <= '0;
      enable     <= 1'b0;
      wenable    <= '0;
      bram_data  <= '0;
      data_point <= '0;
      rd_error   <= 1'b0;
      rd_issue   <= 1'b0;
      rd_pipe    <= '0;
    end else begin
      enable   <= 1'b0;
      wenable  <= '0;
      rd_error <= 1'b0;
      rd_issue <= 1'b0;
      rd_pipe  <= (rd_pipe << 1) | READ_LATENCY'(rd_issue);

      if (start_ok) begin
        // A start in READY wins over a simultaneous read request.
        state    <= WAIT_RST;
        size_q   <= bus.i_batch_norm_weights_size;
        addr_cnt <= '0;
        bank_cnt <= '0;
      end else begin
        case (state)
          WAIT_RST: begin
            if (!bus.i_reset_busy) state <= (size_q != '0) ? LOAD : READY;
          end
          LOAD: begin
            if (xfer) begin
              enable     <= 1'b1;
              wenable    <= OUTPUT_BRAM_NUM'(1) << bank_cnt;
              bram_data  <= bus.i_data;
              data_point <= addr_cnt << 2;
              if (last_bank) begin
                bank_cnt <= '0;
                addr_cnt <= addr_cnt + W'(1);
                if (last_addr) state <= READY;
              end else begin
                bank_cnt <= bank_cnt + BANK_W'(1);
              end
            end
          end
          READY: begin
            if (bus.i_rd_req) begin
              if (bus.i_rd_index < size_q) begin
                enable     <= 1'b1;
                data_point <= bus.i_rd_index << 2;
                rd_issue   <= 1'b1;
              end else begin
                rd_error <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cnn_batch_norm_weights_loader.sv
// Directed bench for the batch-norm weights loader: load, handshake stalls,
// zero size, reads, and mid-load reset with restart.
module tb_cnn_batch_norm_weights_loader;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  cnn_batch_norm_weights_loader_if #(
    .OUTPUT_BRAM_NUM(4), .DATA_WIDTH(32), .BATCH_NORM_WEIGHTS_WIDTH(8)
  ) bus ();

  cnn_batch_norm_weights_loader #(
    .OUTPUT_BRAM_NUM(4), .DATA_WIDTH(32), .BATCH_NORM_WEIGHTS_WIDTH(8), .READ_LATENCY(2)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  logic [3:0]  wlog_wen[$];
  logic [31:0] wlog_data[$];
  logic [7:0]  wlog_pt[$];
  int          wlog_cyc[$];
  int          en_count;
  int          ld_rise;
  logic        ld_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.o_enable) en_count++;
      if (bus.o_enable && bus.o_wenable != 4'b0) begin
        wlog_wen.push_back(bus.o_wenable);
        wlog_data.push_back(bus.o_bram_data);
        wlog_pt.push_back(bus.o_data_point);
        wlog_cyc.push_back(cyc);
      end
      if (bus.o_load_done && !ld_prev) ld_rise = cyc;
      ld_prev = bus.o_load_done;
    end else begin
      ld_prev = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wlog_wen.delete();
    wlog_data.delete();
    wlog_pt.delete();
    wlog_cyc.delete();
    en_count = 0;
    ld_rise  = -1;
  endtask

  task automatic start_load(input logic [7:0] size);
    bus.i_batch_norm_weights_size = size;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic stream(input int n, input logic [31:0] base, input bit bubbles,
                        output int sent, output int busy_viol);
    logic xfer;
    sent = 0;
    busy_viol = 0;
    for (int i = 0; i < 200 && sent < n; i++) begin
      bus.i_data       = base + 32'(sent);
      bus.i_data_valid = bubbles ? (i % 2 == 0) : 1'b1;
      bus.i_reset_busy = bubbles && (i >= 6) && (i < 8);
      #1;
      if (bus.i_reset_busy && bus.o_data_ready) busy_viol++;
      xfer = bus.i_data_valid && bus.o_data_ready;
      @(posedge clk);
      #1;
      if (xfer) sent++;
    end
    bus.i_data_valid = 1'b0;
    bus.i_reset_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_start = 0; bus.i_batch_norm_weights_size = 0; bus.i_reset_busy = 0;
    bus.i_data_valid = 0; bus.i_data = 0; bus.i_rd_req = 0; bus.i_rd_index = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.o_enable, bus.o_wenable, bus.o_bram_data, bus.o_data_point} !== '0) begin
      n_errors++;
      $display("FAIL reset_write_outputs: en=%b wen=%b data=%h pt=%h, expected all 0",
               bus.o_enable, bus.o_wenable, bus.o_bram_data, bus.o_data_point);
    end
    n_checks++;
    if ({bus.o_rd_valid, bus.o_rd_error, bus.o_load_done, bus.o_busy, bus.o_data_ready} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_status: rv=%b re=%b done=%b busy=%b rdy=%b, expected all 0",
               bus.o_rd_valid, bus.o_rd_error, bus.o_load_done, bus.o_busy, bus.o_data_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_load();
    int sent, bv;
    clear_logs();
    start_load(8'd2);
    n_checks++;
    if (bus.o_busy !== 1'b1) begin
      n_errors++; $display("FAIL basic_busy_after_start: got %b expected 1", bus.o_busy);
    end
    stream(8, 32'h10, 1'b0, sent, bv);
    n_checks++;
    if (sent != 8) begin
      n_errors++; $display("FAIL basic_transfers: got %0d expected 8", sent);
    end
    tick(); tick();
    n_checks++;
    if (wlog_wen.size() != 8) begin
      n_errors++; $display("FAIL basic_write_count: got %0d expected 8", wlog_wen.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (wlog_wen[k] !== 4'(1 << (k % 4)) || wlog_pt[k] !== 8'((k / 4) * 4) ||
            wlog_data[k] !== 32'h10 + 32'(k)) begin
          n_errors++;
          $display("FAIL basic_write_%0d: wen=%b pt=%0d data=%h, expected wen=%b pt=%0d data=%h",
                   k, wlog_wen[k], wlog_pt[k], wlog_data[k], 4'(1 << (k % 4)), (k / 4) * 4, 32'h10 + k);
        end
      end
      n_checks++;
      if (ld_rise != wlog_cyc[7]) begin
        n_errors++; $display("FAIL basic_done_timing: done rose cycle %0d, expected %0d", ld_rise, wlog_cyc[7]);
      end
    end
    n_checks++;
    if (en_count != 8) begin
      n_errors++; $display("FAIL basic_enable_cycles: got %0d expected 8", en_count);
    end
    n_checks++;
    if (bus.o_load_done !== 1'b1 || bus.o_busy !== 1'b0) begin
      n_errors++; $display("FAIL basic_final_state: done=%b busy=%b expected 1 0", bus.o_load_done, bus.o_busy);
    end
  endtask

  task automatic test_reads();
    bus.i_rd_req = 1'b1; bus.i_rd_index = 8'd1;
    tick();
    bus.i_rd_req = 1'b0;
    n_checks++;
    if (bus.o_enable !== 1'b1 || bus.o_wenable !== 4'b0 || bus.o_data_point !== 8'd4 || bus.o_rd_error !== 1'b0) begin
      n_errors++;
      $display("FAIL read1_issue: en=%b wen=%b pt=%0d err=%b expected 1 0000 4 0",
               bus.o_enable, bus.o_wenable, bus.o_data_point, bus.o_rd_error);
    end
    tick();
    n_checks++;
    if (bus.o_enable !== 1'b0 || bus.o_rd_valid !== 1'b0) begin
      n_errors++; $display("FAIL read1_t2: en=%b rv=%b expected 0 0", bus.o_enable, bus.o_rd_valid);
    end
    tick();
    n_checks++;
    if (bus.o_rd_valid !== 1'b1) begin
      n_errors++; $display("FAIL read1_valid: got %b expected 1", bus.o_rd_valid);
    end
    tick();
    n_checks++;
    if (bus.o_rd_valid !== 1'b0) begin
      n_errors++; $display("FAIL read1_valid_width: got %b expected 0", bus.o_rd_valid);
    end

    bus.i_rd_req = 1'b1; bus.i_rd_index = 8'd2;
    tick();
    bus.i_rd_req = 1'b0;
    n_checks++;
    if (bus.o_rd_error !== 1'b1 || bus.o_enable !== 1'b0) begin
      n_errors++; $display("FAIL read_oob: err=%b en=%b expected 1 0", bus.o_rd_error, bus.o_enable);
    end
    tick();
    n_checks++;
    if (bus.o_rd_error !== 1'b0) begin
      n_errors++; $display("FAIL read_oob_pulse: err=%b expected 0", bus.o_rd_error);
    end
    tick(); tick();
    n_checks++;
    if (bus.o_rd_valid !== 1'b0) begin
      n_errors++; $display("FAIL read_oob_novalid: rv=%b expected 0", bus.o_rd_valid);
    end

    bus.i_rd_req = 1'b1; bus.i_rd_index = 8'd0;
    tick();
    bus.i_rd_index = 8'd1;
    n_checks++;
    if (bus.o_enable !== 1'b1 || bus.o_data_point !== 8'd0) begin
      n_errors++; $display("FAIL b2b_first: en=%b pt=%0d expected 1 0", bus.o_enable, bus.o_data_point);
    end
    tick();
    bus.i_rd_req = 1'b0;
    n_checks++;
    if (bus.o_enable !== 1'b1 || bus.o_data_point !== 8'd4) begin
      n_errors++; $display("FAIL b2b_second: en=%b pt=%0d expected 1 4", bus.o_enable, bus.o_data_point);
    end
    tick();
    n_checks++;
    if (bus.o_rd_valid !== 1'b1) begin
      n_errors++; $display("FAIL b2b_valid0: rv=%b expected 1", bus.o_rd_valid);
    end
    tick();
    n_checks++;
    if (bus.o_rd_valid !== 1'b1) begin
      n_errors++; $display("FAIL b2b_valid1: rv=%b expected 1", bus.o_rd_valid);
    end
    tick();
    n_checks++;
    if (bus.o_rd_valid !== 1'b0 || bus.o_enable !== 1'b0) begin
      n_errors++; $display("FAIL b2b_end: rv=%b en=%b expected 0 0", bus.o_rd_valid, bus.o_enable);
    end
  endtask

  task automatic test_reset_busy_wait();
    int sent, bv;
    clear_logs();
    bus.i_reset_busy = 1'b1;
    bus.i_rd_req = 1'b1; bus.i_rd_index = 8'd0;
    start_load(8'd2);
    bus.i_rd_req = 1'b0;
    n_checks++;
    if (bus.o_enable !== 1'b0 || bus.o_busy !== 1'b1) begin
      n_errors++; $display("FAIL start_beats_read: en=%b busy=%b expected 0 1", bus.o_enable, bus.o_busy);
    end
    for (int i = 0; i < 5; i++) begin
      bus.i_data_valid = 1'b1; bus.i_data = 32'h20;
      #1;
      n_checks++;
      if (bus.o_data_ready !== 1'b0 || bus.o_enable !== 1'b0) begin
        n_errors++; $display("FAIL rstbusy_hold_%0d: rdy=%b en=%b expected 0 0", i, bus.o_data_ready, bus.o_enable);
      end
      tick();
    end
    stream(8, 32'h20, 1'b0, sent, bv);
    tick(); tick();
    n_checks++;
    if (wlog_wen.size() != 8 || en_count != 8) begin
      n_errors++; $display("FAIL rstbusy_writes: got %0d writes %0d enables expected 8 8", wlog_wen.size(), en_count);
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (wlog_wen[k] !== 4'(1 << (k % 4)) || wlog_pt[k] !== 8'((k / 4) * 4) || wlog_data[k] !== 32'h20 + 32'(k)) begin
          n_errors++; $display("FAIL rstbusy_write_%0d: wen=%b pt=%0d data=%h", k, wlog_wen[k], wlog_pt[k], wlog_data[k]);
        end
      end
    end
  endtask

  task automatic test_bubbles();
    int sent, bv;
    clear_logs();
    start_load(8'd2);
    stream(8, 32'h30, 1'b1, sent, bv);
    tick(); tick();
    n_checks++;
    if (bv != 0) begin
      n_errors++; $display("FAIL bubbles_ready_while_busy: got %0d cycles expected 0", bv);
    end
    n_checks++;
    if (wlog_wen.size() != 8 || en_count != 8) begin
      n_errors++; $display("FAIL bubbles_writes: got %0d writes %0d enables expected 8 8", wlog_wen.size(), en_count);
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (wlog_wen[k] !== 4'(1 << (k % 4)) || wlog_pt[k] !== 8'((k / 4) * 4) || wlog_data[k] !== 32'h30 + 32'(k)) begin
          n_errors++; $display("FAIL bubbles_write_%0d: wen=%b pt=%0d data=%h", k, wlog_wen[k], wlog_pt[k], wlog_data[k]);
        end
      end
    end
  endtask

  task automatic test_zero_size();
    clear_logs();
    start_load(8'd0);
    n_checks++;
    if (bus.o_busy !== 1'b1 || bus.o_load_done !== 1'b0) begin
      n_errors++; $display("FAIL zero_wait: busy=%b done=%b expected 1 0", bus.o_busy, bus.o_load_done);
    end
    tick();
    n_checks++;
    if (bus.o_load_done !== 1'b1 || bus.o_busy !== 1'b0) begin
      n_errors++; $display("FAIL zero_done: done=%b busy=%b expected 1 0", bus.o_load_done, bus.o_busy);
    end
    bus.i_rd_req = 1'b1; bus.i_rd_index = 8'd0;
    tick();
    bus.i_rd_req = 1'b0;
    n_checks++;
    if (bus.o_rd_error !== 1'b1 || bus.o_enable !== 1'b0) begin
      n_errors++; $display("FAIL zero_read_err: err=%b en=%b expected 1 0", bus.o_rd_error, bus.o_enable);
    end
    tick();
    n_checks++;
    if (wlog_wen.size() != 0 || en_count != 0) begin
      n_errors++; $display("FAIL zero_no_writes: got %0d writes %0d enables expected 0 0", wlog_wen.size(), en_count);
    end
  endtask

  task automatic test_mid_load_reset();
    int sent, bv;
    clear_logs();
    start_load(8'd2);
    stream(3, 32'h40, 1'b0, sent, bv);
    n_checks++;
    if (sent != 3) begin
      n_errors++; $display("FAIL midreset_pre_transfers: got %0d expected 3", sent);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_enable, bus.o_wenable, bus.o_bram_data, bus.o_data_point, bus.o_rd_valid,
         bus.o_rd_error, bus.o_load_done, bus.o_busy, bus.o_data_ready} !== '0) begin
      n_errors++;
      $display("FAIL midreset_outputs: en=%b wen=%b data=%h pt=%h done=%b busy=%b, expected all 0",
               bus.o_enable, bus.o_wenable, bus.o_bram_data, bus.o_data_point, bus.o_load_done, bus.o_busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    start_load(8'd2);
    stream(8, 32'h50, 1'b0, sent, bv);
    tick(); tick();
    n_checks++;
    if (wlog_wen.size() != 8) begin
      n_errors++; $display("FAIL restart_writes: got %0d expected 8", wlog_wen.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (wlog_wen[k] !== 4'(1 << (k % 4)) || wlog_pt[k] !== 8'((k / 4) * 4) || wlog_data[k] !== 32'h50 + 32'(k)) begin
          n_errors++; $display("FAIL restart_write_%0d: wen=%b pt=%0d data=%h", k, wlog_wen[k], wlog_pt[k], wlog_data[k]);
        end
      end
    end
    n_checks++;
    if (bus.o_load_done !== 1'b1) begin
      n_errors++; $display("FAIL restart_done: got %b expected 1", bus.o_load_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_reads();
    test_reset_busy_wait();
    test_bubbles();
    test_zero_size();
    test_mid_load_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
